// File: rtl/load_cache_arbiter_if.sv
// Request/response and cache-port bundle between the load reservation stations,
// the arbiter and the data cache read port.
interface load_cache_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int WORD_SIZE = 32
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*WORD_SIZE-1:0] req_addr;
   logic [NUM_REQ-1:0]           gnt;
   logic [NUM_REQ-1:0]           resp_valid;
   logic [WORD_SIZE-1:0]         resp_data;
   logic [WORD_SIZE-1:0]         c_ptr;
   logic                         c_read_enable;
   logic [WORD_SIZE-1:0]         c_out;
   logic                         c_hit;

   // The arbiter side: takes station requests and cache data, drives grants and the cache port.
   modport slave (
      input  req_valid, req_addr, c_out, c_hit,
      output gnt, resp_valid, resp_data, c_ptr, c_read_enable
   );

   modport master (
      output req_valid, req_addr, c_out, c_hit,
      input  gnt, resp_valid, resp_data, c_ptr, c_read_enable
   );
endinterface

// File: rtl/load_cache_arbiter.sv
// Round-robin arbiter sharing one data-cache read port among the load reservation
// stations: lookup, optional fixed miss stall, then a one-cycle response to the owner.
module load_cache_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int REQ_INDEX    = 2,
   parameter int WORD_SIZE    = 32,
   parameter int MISS_LATENCY = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   load_cache_arbiter_if.slave  bus,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] miss_count
);

   localparam int STALL_W = $clog2(MISS_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT, RESP} state_t;

   state_t                 state_q, state_d;
   logic [REQ_INDEX-1:0]   owner_q, owner_d;
   logic [REQ_INDEX-1:0]   rr_ptr_q, rr_ptr_d;
   logic [STALL_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
   logic [WORD_SIZE-1:0]   resp_data_q, resp_data_d;
   logic [WORD_SIZE-1:0]   c_ptr_q, c_ptr_d;
   logic                   c_read_enable_q, c_read_enable_d;
   logic                   busy_q, busy_d;
   logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;

   logic                   found;
   logic [REQ_INDEX-1:0]   pick;
   logic [REQ_INDEX-1:0]   cand;

   // First requesting station at or after rr_ptr, wrapping; X on req_valid counts as idle.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = REQ_INDEX'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && (bus.req_valid[cand] === 1'b1)) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      rr_ptr_d        = rr_ptr_q;
      stall_cnt_d     = stall_cnt_q;
      gnt_d           = gnt_q;
      resp_valid_d    = '0;
      resp_data_d     = resp_data_q;
      c_ptr_d         = c_ptr_q;
      c_read_enable_d = c_read_enable_q;
      miss_count_d    = miss_count_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               owner_d         = pick;
               gnt_d           = NUM_REQ'(1) << pick;
               c_ptr_d         = bus.req_addr[int'(pick)*WORD_SIZE +: WORD_SIZE];
               c_read_enable_d = 1'b1;
               state_d         = LOOKUP;
            end
         end
         LOOKUP: begin
            if (bus.c_hit) begin
               resp_data_d     = bus.c_out;
               c_read_enable_d = 1'b0;
               resp_valid_d    = gnt_q;
               state_d         = RESP;
            end else begin
               stall_cnt_d = STALL_W'(MISS_LATENCY);
               if (miss_count_q != '1) begin
                  miss_count_d = miss_count_q + CNT_WIDTH'(1);
               end
               state_d = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            stall_cnt_d = stall_cnt_q - STALL_W'(1);
            // The cache data is trusted once the stall window has elapsed, hit flag or not.
            if (stall_cnt_q == STALL_W'(1)) begin
               resp_data_d     = bus.c_out;
               c_read_enable_d = 1'b0;
               resp_valid_d    = gnt_q;
               state_d         = RESP;
            end
         end
         RESP: begin
            gnt_d    = '0;
            rr_ptr_d = (owner_q == REQ_INDEX'(NUM_REQ - 1)) ? '0 : owner_q + REQ_INDEX'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         owner_q         <= '0;
         rr_ptr_q        <= '0;
         stall_cnt_q     <= '0;
         gnt_q           <= '0;
         resp_valid_q    <= '0;
         resp_data_q     <= '0;
         c_ptr_q         <= '0;
         c_read_enable_q <= 1'b0;
         busy_q          <= 1'b0;
         miss_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         rr_ptr_q        <= rr_ptr_d;
         stall_cnt_q     <= stall_cnt_d;
         gnt_q           <= gnt_d;
         resp_valid_q    <= resp_valid_d;
         resp_data_q     <= resp_data_d;
         c_ptr_q         <= c_ptr_d;
         c_read_enable_q <= c_read_enable_d;
         busy_q          <= busy_d;
         miss_count_q    <= miss_count_d;
      end
   end

   assign bus.gnt           = gnt_q;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_data     = resp_data_q;
   assign bus.c_ptr         = c_ptr_q;
   assign bus.c_read_enable = c_read_enable_q;
   assign busy              = busy_q;
   assign miss_count        = miss_count_q;

endmodule

// File: tb/tb_load_cache_arbiter.sv
// Self-checking bench for load_cache_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_load_cache_arbiter;

   localparam int NR = 4;
   localparam int W  = 32;
   localparam int ML = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy, busy2;
   logic [15:0] miss_count;
   logic [1:0]  miss_count2;

   int checks = 0;
   int errors = 0;

   load_cache_arbiter_if #(.NUM_REQ(NR), .WORD_SIZE(W)) bus ();
   load_cache_arbiter_if #(.NUM_REQ(NR), .WORD_SIZE(W)) bus2 ();

   load_cache_arbiter #(.NUM_REQ(NR), .REQ_INDEX(2), .WORD_SIZE(W), .MISS_LATENCY(ML), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .bus(bus), .busy(busy), .miss_count(miss_count));

   // Second copy with a 2-bit miss counter sees identical traffic to exercise saturation.
   load_cache_arbiter #(.NUM_REQ(NR), .REQ_INDEX(2), .WORD_SIZE(W), .MISS_LATENCY(ML), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset(reset), .bus(bus2), .busy(busy2), .miss_count(miss_count2));

   always #5 clk = ~clk;

   // Cache: addresses with bit 12 set miss; data is a fixed function of the address.
   function automatic logic cacheHit(input logic [31:0] a);
      return ~a[12];
   endfunction

   function automatic logic [31:0] cacheData(input logic [31:0] a);
      if (a == 32'h40)   return 32'hDEAD_BEEF;
      if (a == 32'h1000) return 32'h0000_1234;
      return a * 3 + 32'h11;
   endfunction

   assign bus.c_out     = cacheData(bus.c_ptr);
   assign bus.c_hit     = cacheHit(bus.c_ptr);
   assign bus2.c_out    = cacheData(bus2.c_ptr);
   assign bus2.c_hit    = cacheHit(bus2.c_ptr);
   assign bus2.req_valid = bus.req_valid;
   assign bus2.req_addr  = bus.req_addr;

   function automatic int pickReq(input int rr, input logic [NR-1:0] rv);
      for (int k = 0; k < NR; k++) begin
         if (rv[(rr + k) % NR] === 1'b1) return (rr + k) % NR;
      end
      return -1;
   endfunction

   // Model: a transaction is "age" cycles past its grant; the response lands at age 2 or 2+ML.
   logic        mActive = 1'b0;
   int          mOwner  = 0;
   int          mRr     = 0;
   int          mAge    = 0;
   int          mRespAt = 0;
   int          mMiss   = 0;
   logic [31:0] mCptr   = '0;
   logic [31:0] mData   = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mActive <= 1'b0; mOwner <= 0; mRr <= 0; mAge <= 0;
         mRespAt <= 0; mMiss <= 0; mCptr <= '0; mData <= '0;
      end else if (!mActive) begin
         if (pickReq(mRr, bus.req_valid) >= 0) begin
            mActive <= 1'b1;
            mOwner  <= pickReq(mRr, bus.req_valid);
            mCptr   <= bus.req_addr[pickReq(mRr, bus.req_valid)*W +: W];
            mAge    <= 1;
            mRespAt <= 0;
         end
      end else if (mAge == mRespAt) begin
         mActive <= 1'b0;
         mRr     <= (mOwner + 1) % NR;
      end else begin
         mAge  <= mAge + 1;
         mData <= cacheData(mCptr);
         if (mAge == 1) begin
            mRespAt <= cacheHit(mCptr) ? 2 : 2 + ML;
            if (!cacheHit(mCptr)) mMiss <= mMiss + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareLoop();
      logic [3:0] expGnt, expRv;
      logic       expRe;
      forever begin
         @(negedge clk);
         if (!reset) begin
            expGnt = mActive ? 4'(1 << mOwner) : 4'b0;
            expRe  = mActive && ((mRespAt == 0) || (mAge < mRespAt));
            expRv  = (mActive && mAge == mRespAt) ? expGnt : 4'b0;
            checkOutput("gnt", bus.gnt, expGnt);
            checkOutput("gnt_onehot0", $onehot0(bus.gnt), 1);
            checkOutput("c_read_enable", bus.c_read_enable, expRe);
            checkOutput("resp_valid", bus.resp_valid, expRv);
            checkOutput("busy", busy, mActive);
            checkOutput("c_ptr", bus.c_ptr, mCptr);
            checkOutput("miss_count", miss_count, mMiss);
            checkOutput("miss_count_sat", miss_count2, (mMiss > 3) ? 3 : mMiss);
            if (expRv != 0) checkOutput("resp_data", bus.resp_data, mData);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int st, input logic [31:0] addr, input logic on);
      bus.req_addr[st*W +: W] = addr;
      bus.req_valid[st]       = on;
   endtask

   // One request on station st; reports grant seen in cycle 1, response cycle, data and read-enable cycles.
   task automatic serveOne(input int st, input logic [31:0] addr, output int respCyc,
                           output logic [31:0] data, output int reCyc, output logic [3:0] gnt1);
      respCyc = 0; reCyc = 0; data = '0; gnt1 = '0;
      applyStimulus(st, addr, 1'b1);
      for (int c = 1; c <= 12 && respCyc == 0; c++) begin
         cycle();
         if (c == 1) gnt1 = bus.gnt;
         if (bus.c_read_enable) reCyc++;
         if (bus.resp_valid[st]) begin
            respCyc = c;
            data    = bus.resp_data;
         end
      end
      applyStimulus(st, addr, 1'b0);
      cycle();
   endtask

   task automatic waitAnyResp(output int st, input bit drop);
      st = -1;
      for (int c = 0; c < 20 && st < 0; c++) begin
         cycle();
         for (int i = NR - 1; i >= 0; i--) if (bus.resp_valid[i]) st = i;
         if (st >= 0 && drop) bus.req_valid[st] = 1'b0;
      end
   endtask

   initial begin
      int          rc, re, st, pulses;
      logic [31:0] d;
      logic [3:0]  g1;
      int          order [5] = '{0, 1, 2, 3, 0};

      bus.req_valid = '0;
      bus.req_addr  = '0;
      reset = 1'b1;
      fork
         compareLoop();
      join_none
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_gnt", bus.gnt, 0);
      checkOutput("rst_resp_valid", bus.resp_valid, 0);
      checkOutput("rst_resp_data", bus.resp_data, 0);
      checkOutput("rst_c_ptr", bus.c_ptr, 0);
      checkOutput("rst_c_read_enable", bus.c_read_enable, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_miss_count", miss_count, 0);
      #2 reset = 1'b0;
      @(negedge clk);

      $display("[TB] single hit on station 1");
      serveOne(1, 32'h40, rc, d, re, g1);
      checkOutput("hit_gnt", g1, 4'b0010);
      checkOutput("hit_resp_cycle", rc, 2);
      checkOutput("hit_resp_data", d, 32'hDEAD_BEEF);
      checkOutput("hit_re_cycles", re, 1);
      checkOutput("hit_c_ptr", bus.c_ptr, 32'h40);
      checkOutput("hit_miss_count", miss_count, 0);

      $display("[TB] single miss on station 0");
      serveOne(0, 32'h1000, rc, d, re, g1);
      checkOutput("miss_gnt", g1, 4'b0001);
      checkOutput("miss_re_cycles", re, 5);
      checkOutput("miss_resp_cycle", rc, 6);
      checkOutput("miss_resp_data", d, 32'h1234);
      checkOutput("miss_count_1", miss_count, 1);

      $display("[TB] priority after serving station 2");
      serveOne(2, 32'h220, rc, d, re, g1);
      checkOutput("prio_first_cycle", rc, 2);
      applyStimulus(0, 32'h20, 1'b1);
      applyStimulus(2, 32'h220, 1'b1);
      waitAnyResp(st, 1'b1);
      checkOutput("prio_next_0", st, 0);
      waitAnyResp(st, 1'b1);
      checkOutput("prio_then_2", st, 2);
      cycle();

      $display("[TB] early drop on station 3");
      applyStimulus(3, 32'h300, 1'b1);
      cycle();
      applyStimulus(3, 32'h300, 1'b0);
      pulses = 0;
      d = '0;
      repeat (8) begin
         cycle();
         if (bus.resp_valid[3]) begin
            pulses++;
            d = bus.resp_data;
         end
      end
      checkOutput("drop_pulses", pulses, 1);
      checkOutput("drop_data", d, 32'h911);

      $display("[TB] five misses for saturation");
      for (int k = 0; k < 5; k++) serveOne(1, 32'h1010 + 32'(k * 16), rc, d, re, g1);
      checkOutput("sat_count16", miss_count, 6);
      checkOutput("sat_count2", miss_count2, 3);

      $display("[TB] reset during miss stall");
      applyStimulus(2, 32'h1100, 1'b1);
      cycle();
      cycle();
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_mid_re", bus.c_read_enable, 0);
      checkOutput("rst_mid_gnt", bus.gnt, 0);
      checkOutput("rst_mid_busy", busy, 0);
      applyStimulus(2, 32'h1100, 1'b0);
      cycle();
      #2 reset = 1'b0;
      pulses = 0;
      repeat (6) begin
         cycle();
         if (bus.resp_valid != 0) pulses++;
      end
      checkOutput("rst_mid_no_resp", pulses, 0);
      applyStimulus(0, 32'h500, 1'b1);
      applyStimulus(3, 32'h600, 1'b1);
      waitAnyResp(st, 1'b1);
      checkOutput("post_rst_first", st, 0);
      waitAnyResp(st, 1'b1);
      checkOutput("post_rst_second", st, 3);
      cycle();

      $display("[TB] round robin with all stations requesting");
      for (int i = 0; i < NR; i++) applyStimulus(i, 32'((i + 1) * 256), 1'b1);
      for (int k = 0; k < 5; k++) begin
         waitAnyResp(st, 1'b0);
         checkOutput($sformatf("rr_order_%0d", k), st, order[k]);
      end
      bus.req_valid = '0;
      repeat (8) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout reached without finishing");
      $fatal(1, "[TB] timeout");
   end

endmodule
